iir_filter_gen: RTL and testbench
=================================

// Module: iir_filter_gen
// PURPOSE
//  Parametrised successor of the 1st-order IIR datapath: direct form II, y[n]=b0*w[n]+b1*w[n-1],
//  w[n]=x[n]-a1*w[n-1]. Adds generic width/format, output pipelining, selectable saturation,
//  atomic coefficient load, state clear and a sticky overflow flag.
//  Sits between data_maker-style source and data_sink-style checker; same VIN/VOUT streaming.
// PARAMETERS
//  NB    12  data and coefficient width, signed two's complement
//  FRAC  11  fractional bits of coefficients (Q(NB-FRAC).FRAC); products shifted right by FRAC
//  PIPE  1   extra output-path register stages (0..4); feedback loop is never pipelined
//  SAT   1   1: saturate w and y to NB bits; 0: wrap (drop MSBs)
// PORTS
//  CLK      in   1   clock, rising edge
//  RST_n    in   1   asynchronous active-low reset
//  DIN      in   NB  input sample x[n]
//  VIN      in   1   DIN valid; one sample consumed per cycle with VIN=1
//  b0,b1,a1 in   NB  coefficients, captured only on COEF_LD
//  COEF_LD  in   1   load b0/b1/a1 into active coefficient registers
//  CLR      in   1   sync clear of filter state w[n-1] and output pipeline
//  DOUT     out  NB  filtered sample y[n]
//  VOUT     out  1   DOUT valid, one-cycle strobe per consumed sample
//  OVF      out  1   sticky: any saturation/wrap event since reset or CLR
// BEHAVIOUR
//  Reset (async, RST_n=0): DOUT=0, VOUT=0, OVF=0, w state=0, pipeline valids=0, coefs=0.
//  Cycle with VIN=1 at edge k: w[n] computed from DIN and active coefs, w[n-1]<=w[n].
//  Latency: VOUT=1 with matching DOUT exactly PIPE+1 cycles after the VIN cycle; throughput 1/clk.
//  VIN=0: state frozen; valid bubbles propagate; DOUT holds last value when VOUT=0.
//  Arithmetic: NBxNB -> 2NB signed product; arithmetic shift right by FRAC (floor, no rounding);
//   sums in NB+2 bits; result reduced to NB bits per SAT (clip to +/-(2^(NB-1)) limits or wrap).
//   Reduction applied to w[n] before storage and to y[n]; any out-of-range event sets OVF.
//  COEF_LD: active coefs <= b0/b1/a1 at edge. COEF_LD and VIN same cycle: that sample uses OLD
//   coefs; new coefs apply from next VIN cycle. Samples already in output pipe are unaffected.
//  CLR: w[n-1]<=0, all pipeline valids<=0, OVF<=0; VIN in a CLR cycle is discarded (no VOUT).
//   Active coefs kept. CLR has priority over VIN; COEF_LD in a CLR cycle still loads.
//  Reset mid-stream: all in-flight samples dropped, no VOUT until new VIN after RST_n release.
// STRUCTURE
//  iir_defs.vh: NB/FRAC defaults, saturation limits MAXV/MINV, PIPE upper bound.
//  Sub-module iir_sat_trunc (combinational): input NB+2 bits, params NB/SAT -> NB result + ovf.
//   Instantiated twice (w path, y path). Output pipe: generate-loop shift register of
//   {valid,data}; PIPE=0 leaves only the DOUT/VOUT register.
// TESTING (NB=12, FRAC=11, PIPE=1, SAT=1 unless noted)
//  FIR only: b0=b1=0x400, a1=0, impulse DIN=0x400 then 0 -> DOUT 0x200,0x200,0x000; VOUT 2 cyc after VIN.
//  Recursive: b0=0x400,b1=0,a1=0xC00 (-0.5), impulse 0x400 -> DOUT 0x200,0x100,0x080,0x040.
//  Saturation: b0=0x7FF,b1=0,a1=0xC00, DIN=0x7FF constant -> w clips 0x7FF, DOUT settles 0x7FE,
//   OVF=1; SAT=0 same stimulus -> OVF=1 and DOUT differs (wrapped).
//  Gaps/latency: VIN pattern 1,0,0,1,1 -> VOUT pattern identical shifted by PIPE+1; PIPE=0 and 3.
//  COEF_LD with VIN same cycle -> that sample matches old-coef model, next matches new.
//  RST_n low mid-stream and CLR mid-stream -> no stale VOUT; next impulse reproduces case 2 exactly.

Source files
------------

// File: rtl/iir_filter_gen_pkg.sv
// Shared defaults and saturation limits for the parametrised 1st-order IIR filter.
package iir_filter_gen_pkg;

    localparam int unsigned NB_DEF   = 12;
    localparam int unsigned FRAC_DEF = 11;
    localparam int unsigned PIPE_MAX = 4;

    function automatic longint sat_max(input int unsigned nb);
        return (longint'(1) << (nb - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned nb);
        return -(longint'(1) << (nb - 1));
    endfunction

endpackage

// File: rtl/iir_filter_gen_sat_trunc.sv
// Reduces an NB+2 bit signed sum to NB bits, either clipping or wrapping;
// flags any value outside the NB-bit range.
module iir_filter_gen_sat_trunc
    import iir_filter_gen_pkg::*;
#(
    parameter int unsigned NB  = NB_DEF,
    parameter int unsigned SAT = 1
) (
    input  logic signed [NB+1:0] din,
    output logic signed [NB-1:0] dout,
    output logic                 ovf
);

    localparam logic signed [NB-1:0] MAXV = NB'(sat_max(NB));
    localparam logic signed [NB-1:0] MINV = NB'(sat_min(NB));

    always_comb begin
        // In range only when the two guard bits replicate the NB-bit sign.
        ovf  = (din[NB+1:NB-1] != '0) && (din[NB+1:NB-1] != '1);
        dout = din[NB-1:0];
        if (SAT != 0 && ovf) begin
            dout = din[NB+1] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/iir_filter_gen.sv
// Direct-form-II 1st-order IIR: w[n]=x[n]-a1*w[n-1], y[n]=b0*w[n]+b1*w[n-1],
// with atomic coefficient load, sync state clear, output pipeline and sticky overflow.
module iir_filter_gen
    import iir_filter_gen_pkg::*;
#(
    parameter int unsigned NB   = NB_DEF,
    parameter int unsigned FRAC = FRAC_DEF,
    parameter int unsigned PIPE = 1,
    parameter int unsigned SAT  = 1
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic signed [NB-1:0] DIN,
    input  logic                 VIN,
    input  logic signed [NB-1:0] b0,
    input  logic signed [NB-1:0] b1,
    input  logic signed [NB-1:0] a1,
    input  logic                 COEF_LD,
    input  logic                 CLR,
    output logic signed [NB-1:0] DOUT,
    output logic                 VOUT,
    output logic                 OVF
);

    localparam int unsigned SW = NB + 2;

    logic signed [NB-1:0]   c_b0, c_b1, c_a1;
    logic signed [NB-1:0]   w_prev, w_new, y_new;
    logic signed [2*NB-1:0] p_a1, p_b0, p_b1;
    logic signed [SW-1:0]   w_sum, y_sum;
    logic                   ovf_w, ovf_y;
    logic                   take;

    logic                   pv [PIPE+1];
    logic signed [NB-1:0]   pd [PIPE+1];

    assign take  = VIN && !CLR;

    assign p_a1  = c_a1 * w_prev;
    assign w_sum = SW'(DIN) - SW'(p_a1 >>> FRAC);

    iir_filter_gen_sat_trunc #(.NB(NB), .SAT(SAT)) u_sat_w (
        .din  (w_sum),
        .dout (w_new),
        .ovf  (ovf_w)
    );

    assign p_b0  = c_b0 * w_new;
    assign p_b1  = c_b1 * w_prev;
    assign y_sum = SW'(p_b0 >>> FRAC) + SW'(p_b1 >>> FRAC);

    iir_filter_gen_sat_trunc #(.NB(NB), .SAT(SAT)) u_sat_y (
        .din  (y_sum),
        .dout (y_new),
        .ovf  (ovf_y)
    );

    // Coefficients update after this edge's sample has used the old set.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            c_b0 <= '0;
            c_b1 <= '0;
            c_a1 <= '0;
        end else if (COEF_LD) begin
            c_b0 <= b0;
            c_b1 <= b1;
            c_a1 <= a1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            w_prev <= '0;
            OVF    <= 1'b0;
        end else if (CLR) begin
            w_prev <= '0;
            OVF    <= 1'b0;
        end else if (VIN) begin
            w_prev <= w_new;
            if (ovf_w || ovf_y) begin
                OVF <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pv[0] <= 1'b0;
            pd[0] <= '0;
        end else begin
            pv[0] <= take;
            if (take) begin
                pd[0] <= y_new;
            end
        end
    end

    // Stage data only advances with a valid sample, so DOUT keeps the last delivered value.
    for (genvar g = 1; g <= PIPE; g++) begin : g_pipe
        always_ff @(posedge CLK or negedge RST_n) begin
            if (!RST_n) begin
                pv[g] <= 1'b0;
                pd[g] <= '0;
            end else begin
                pv[g] <= pv[g-1] && !CLR;
                if (pv[g-1] && !CLR) begin
                    pd[g] <= pd[g-1];
                end
            end
        end
    end

    assign DOUT = pd[PIPE];
    assign VOUT = pv[PIPE];

endmodule

// File: tb/tb_iir_filter_gen.sv
// Self-checking bench: four filter configurations share one stimulus stream and are
// compared every cycle against an arithmetic reference model plus literal expectations.
module tb_iir_filter_gen;

    localparam int MAXE = 4096;
    localparam int PIPE_C [4] = '{1, 1, 0, 3};
    localparam int SAT_C  [4] = '{1, 0, 1, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] din, b0, b1, a1;
    logic        vin, coef_ld, clr;

    logic signed [11:0] dout_a [4];
    logic               vout_a [4];
    logic               ovf_a  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iir_filter_gen #(.NB(12), .FRAC(11), .PIPE(1), .SAT(1)) dut_main (
        .CLK(clk), .RST_n(rst_n), .DIN(din), .VIN(vin), .b0(b0), .b1(b1), .a1(a1),
        .COEF_LD(coef_ld), .CLR(clr), .DOUT(dout_a[0]), .VOUT(vout_a[0]), .OVF(ovf_a[0]));
    iir_filter_gen #(.NB(12), .FRAC(11), .PIPE(1), .SAT(0)) dut_wrap (
        .CLK(clk), .RST_n(rst_n), .DIN(din), .VIN(vin), .b0(b0), .b1(b1), .a1(a1),
        .COEF_LD(coef_ld), .CLR(clr), .DOUT(dout_a[1]), .VOUT(vout_a[1]), .OVF(ovf_a[1]));
    iir_filter_gen #(.NB(12), .FRAC(11), .PIPE(0), .SAT(1)) dut_p0 (
        .CLK(clk), .RST_n(rst_n), .DIN(din), .VIN(vin), .b0(b0), .b1(b1), .a1(a1),
        .COEF_LD(coef_ld), .CLR(clr), .DOUT(dout_a[2]), .VOUT(vout_a[2]), .OVF(ovf_a[2]));
    iir_filter_gen #(.NB(12), .FRAC(11), .PIPE(3), .SAT(1)) dut_p3 (
        .CLK(clk), .RST_n(rst_n), .DIN(din), .VIN(vin), .b0(b0), .b1(b1), .a1(a1),
        .COEF_LD(coef_ld), .CLR(clr), .DOUT(dout_a[3]), .VOUT(vout_a[3]), .OVF(ovf_a[3]));

    // ---------------- reference model ----------------
    int  ecnt = 0;
    bit  hv [MAXE];
    bit  fl [MAXE];
    int  hy [2][MAXE];
    int  wm [2];
    bit  om [2];
    int  cb0, cb1, ca1;
    bit  ev [4];
    int  ey [4];
    bit  eo [4];

    function automatic longint fdiv(input longint p);
        return p >>> 11;
    endfunction

    function automatic int reduce(input longint v, input bit sat, output bit o);
        o = (v > 2047) || (v < -2048);
        if (!o) return int'(v);
        if (sat) return (v > 0) ? 2047 : -2048;
        return ((int'(v) + 2048) & 4095) - 2048;
    endfunction

    always @(posedge clk) begin
        int  k, w, y, x;
        bit  o1, o2, ok;
        ecnt++;
        if (ecnt >= MAXE) begin
            $display("FAIL model_capacity edge %0d exceeds %0d", ecnt, MAXE);
            $fatal(1);
        end
        if (!rst_n) begin
            fl[ecnt] = 1'b1;
            hv[ecnt] = 1'b0;
            wm = '{0, 0};
            om = '{0, 0};
            cb0 = 0; cb1 = 0; ca1 = 0;
            for (int c = 0; c < 4; c++) begin
                ev[c] = 1'b0; ey[c] = 0; eo[c] = 1'b0;
            end
        end else begin
            fl[ecnt] = clr;
            hv[ecnt] = vin && !clr;
            if (clr) begin
                wm = '{0, 0};
                om = '{0, 0};
            end else if (vin) begin
                x = int'($signed(din));
                for (int s = 0; s < 2; s++) begin
                    w = reduce(longint'(x) - fdiv(longint'(ca1) * wm[s]), s == 1, o1);
                    y = reduce(fdiv(longint'(cb0) * w) + fdiv(longint'(cb1) * wm[s]), s == 1, o2);
                    om[s] = om[s] | o1 | o2;
                    wm[s] = w;
                    hy[s][ecnt] = y;
                end
            end
            if (coef_ld) begin
                cb0 = int'($signed(b0));
                cb1 = int'($signed(b1));
                ca1 = int'($signed(a1));
            end
            for (int c = 0; c < 4; c++) begin
                k  = ecnt - PIPE_C[c];
                ok = (k >= 1) && hv[k];
                for (int j = k + 1; j <= ecnt; j++) begin
                    if (j >= 1 && fl[j]) ok = 1'b0;
                end
                ev[c] = ok;
                if (ok) ey[c] = hy[SAT_C[c]][k];
                eo[c] = om[SAT_C[c]];
            end
        end
    end

    // ---------------- checking ----------------
    int cap_q [$];
    int cap_e [$];
    int vcnt [4] = '{0, 0, 0, 0};

    task automatic chk(input string nm, input int c, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d edge %0d: got %0d expected %0d", nm, c, ecnt, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (!rst_n) begin
                chk("reset_vout", c, int'(vout_a[c]), 0);
                chk("reset_dout", c, int'(dout_a[c]), 0);
                chk("reset_ovf",  c, int'(ovf_a[c]),  0);
            end else begin
                chk("vout", c, int'(vout_a[c]), int'(ev[c]));
                chk("dout", c, int'(dout_a[c]), ey[c]);
                chk("ovf",  c, int'(ovf_a[c]),  int'(eo[c]));
                if (vout_a[c]) vcnt[c]++;
            end
        end
        if (rst_n && vout_a[0]) begin
            cap_q.push_back(int'(dout_a[0]));
            cap_e.push_back(ecnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int d, input bit ld, input bit c);
        vin = v; din = 12'(d); coef_ld = ld; clr = c;
        @(posedge clk);
        #1;
        vin = 1'b0; coef_ld = 1'b0; clr = 1'b0;
    endtask

    task automatic setc(input int x0, input int x1, input int xa);
        b0 = 12'(x0); b1 = 12'(x1); a1 = 12'(xa);
        drive(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic clrq();
        cap_q.delete();
        cap_e.delete();
    endtask

    task automatic chk_cap(input string nm, input int idx, input int exp);
        if (idx < cap_q.size()) chk(nm, 0, cap_q[idx], exp);
        else                    chk(nm, 0, -99999, exp);
    endtask

    task automatic impulse_recursive(input string nm);
        clrq();
        drive(1'b1, 'h400, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 0, 1'b0, 1'b0);
        idle(5);
        chk({nm, "_count"}, 0, cap_q.size(), 4);
        chk_cap({nm, "_y0"}, 0, 'h200);
        chk_cap({nm, "_y1"}, 1, 'h100);
        chk_cap({nm, "_y2"}, 2, 'h080);
        chk_cap({nm, "_y3"}, 3, 'h040);
    endtask

    initial begin
        int ve;
        int vstart [4];
        rst_n = 1'b0; din = '0; vin = 1'b0; b0 = '0; b1 = '0; a1 = '0;
        coef_ld = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // FIR only
        drive(1'b0, 0, 1'b0, 1'b1);
        setc('h400, 'h400, 0);
        clrq();
        drive(1'b1, 'h400, 1'b0, 1'b0);
        ve = ecnt;
        drive(1'b1, 0, 1'b0, 1'b0);
        drive(1'b1, 0, 1'b0, 1'b0);
        idle(5);
        chk("fir_count", 0, cap_q.size(), 3);
        chk_cap("fir_y0", 0, 'h200);
        chk_cap("fir_y1", 1, 'h200);
        chk_cap("fir_y2", 2, 'h000);
        chk("fir_latency", 0, (cap_e.size() > 0) ? cap_e[0] - ve : -1, 1);

        // Recursive impulse response
        drive(1'b0, 0, 1'b0, 1'b1);
        setc('h400, 0, 'hC00);
        impulse_recursive("rec");

        // Saturation vs wrap
        drive(1'b0, 0, 1'b0, 1'b1);
        setc('h7FF, 0, 'hC00);
        clrq();
        repeat (6) drive(1'b1, 'h7FF, 1'b0, 1'b0);
        idle(5);
        chk_cap("sat_settle", 5, 'h7FE);
        chk("sat_ovf", 0, int'(ovf_a[0]), 1);
        chk("wrap_ovf", 1, int'(ovf_a[1]), 1);
        chk("wrap_differs", 1, int'(int'(dout_a[1]) != 'h7FE), 1);

        // Gaps: VIN 1,0,0,1,1 gives three strobes on every pipeline depth
        drive(1'b0, 0, 1'b0, 1'b1);
        setc('h400, 'h200, 'hC00);
        for (int c = 0; c < 4; c++) vstart[c] = vcnt[c];
        drive(1'b1, 'h123, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 'hF00, 1'b0, 1'b0);
        drive(1'b1, 'h055, 1'b0, 1'b0);
        idle(6);
        for (int c = 0; c < 4; c++) chk("gap_count", c, vcnt[c] - vstart[c], 3);

        // COEF_LD in the same cycle as VIN: old coefs for that sample
        drive(1'b0, 0, 1'b0, 1'b1);
        setc('h400, 0, 0);
        clrq();
        b0 = 12'h200; b1 = '0; a1 = '0;
        drive(1'b1, 'h400, 1'b1, 1'b0);
        drive(1'b1, 'h400, 1'b0, 1'b0);
        idle(4);
        chk("coef_old", 0, (cap_q.size() > 0) ? cap_q[0] : -99999, 'h200);
        chk("coef_new", 0, (cap_q.size() > 1) ? cap_q[1] : -99999, 'h100);

        // CLR mid-stream with VIN in the clear cycle
        setc('h400, 0, 'hC00);
        repeat (3) drive(1'b1, int'($urandom_range(0, 4095)), 1'b0, 1'b0);
        drive(1'b1, 'h3FF, 1'b0, 1'b1);
        impulse_recursive("clr_mid");

        // Reset mid-stream; coefficients must be reloaded afterwards
        repeat (3) drive(1'b1, int'($urandom_range(0, 4095)), 1'b0, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        setc('h400, 0, 'hC00);
        impulse_recursive("rst_mid");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                b0 = 12'($urandom); b1 = 12'($urandom); a1 = 12'($urandom);
                coef_ld = 1'b1;
            end
            vin = ($urandom_range(0, 3) != 0);
            din = 12'($urandom);
            clr = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            #1;
            vin = 1'b0; coef_ld = 1'b0; clr = 1'b0;
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
